d_mem_resp: RTL and testbench

- Data-memory responder for the multicycle RISC-V core; the slave end of the load/store interface driven by the control unit.
- Accepts one load or store request at a time through a valid/ready handshake and holds a byte-addressed 64-bit memory array.
- Performs byte/half/word/dword access with sign or zero extension, then returns a one-cycle response pulse after a configurable wait.
- Flags misaligned and out-of-range accesses as faults instead of performing them.

---
 rtl/d_mem_resp.sv | 256 +++++++++++++++++++++++++
 tb/tb_d_mem_resp.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/d_mem_resp.sv
// Data-memory responder: valid/ready load/store slave over a byte-addressed 64-bit array.
// Optional zero-fill of the array after reset: D_MEM_CLEAR_ON_RESET_EN.
module d_mem_resp #(
  parameter int WORDSIZE = 64,
  parameter int DEPTH    = 256,
  parameter int LATENCY  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [WORDSIZE-1:0] req_addr,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [WORDSIZE-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [WORDSIZE-1:0] rsp_rdata,
  output logic                rsp_fault,
  output logic                busy
);

  localparam int AW = $clog2(DEPTH);

`ifdef D_MEM_CLEAR_ON_RESET_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2, S_CLEAR = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;
`endif

  // Expands the 2^size byte lanes starting at lane into a bit mask.
  function automatic logic [WORDSIZE-1:0] lane_mask(input logic [1:0] size, input logic [2:0] lane);
    logic [7:0]          bm;
    logic [WORDSIZE-1:0] m;
    case (size)
      2'd0:    bm = 8'h01;
      2'd1:    bm = 8'h03;
      2'd2:    bm = 8'h0F;
      default: bm = 8'hFF;
    endcase
    bm = bm << lane;
    for (int i = 0; i < 8; i++) begin
      m[i*8 +: 8] = {8{bm[i]}};
    end
    return m;
  endfunction

  function automatic logic [WORDSIZE-1:0] store_merge(input logic [WORDSIZE-1:0] word,
                                                      input logic [WORDSIZE-1:0] wdata,
                                                      input logic [1:0] size,
                                                      input logic [2:0] lane);
    logic [WORDSIZE-1:0] m;
    logic [WORDSIZE-1:0] sd;
    m  = lane_mask(size, lane);
    sd = wdata << {lane, 3'b000};
    return (word & ~m) | (sd & m);
  endfunction

  function automatic logic [WORDSIZE-1:0] load_extract(input logic [WORDSIZE-1:0] word,
                                                       input logic [1:0] size,
                                                       input logic [2:0] lane,
                                                       input logic uns);
    logic [WORDSIZE-1:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      2'd0:    return {{(WORDSIZE-8){~uns & sh[7]}}, sh[7:0]};
      2'd1:    return {{(WORDSIZE-16){~uns & sh[15]}}, sh[15:0]};
      2'd2:    return {{(WORDSIZE-32){~uns & sh[31]}}, sh[31:0]};
      default: return sh;
    endcase
  endfunction

  function automatic logic align_fault(input logic [1:0] size, input logic [2:0] low);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return low[0];
      2'd2:    return |low[1:0];
      default: return |low[2:0];
    endcase
  endfunction

  state_t              state_r, state_nxt_s;
  logic [3:0]          cnt_r;
  logic                we_r, uns_r;
  logic [WORDSIZE-1:0] addr_r, wdata_r;
  logic [1:0]          size_r;
  logic                req_ready_r, rsp_valid_r, rsp_fault_r, busy_r;
  logic [WORDSIZE-1:0] rsp_rdata_r;
  logic [WORDSIZE-1:0] mem_r [DEPTH];

  logic                cur_we_s, cur_uns_s;
  logic [WORDSIZE-1:0] cur_addr_s, cur_wdata_s;
  logic [1:0]          cur_size_s;
  logic [AW-1:0]       idx_s;
  logic [2:0]          lane_s;
  logic                fault_s, accept_s, commit_s;
  logic [WORDSIZE-1:0] rd_word_s;
  logic                mem_we_s;
  logic [AW-1:0]       mem_widx_s;
  logic [WORDSIZE-1:0] mem_wdata_s;

`ifdef D_MEM_CLEAR_ON_RESET_EN
  logic                clr_done_r;
  logic [AW-1:0]       clr_idx_r;
`endif

  // In IDLE the live request is decoded so that LATENCY=0 can commit on the accept edge.
  always_comb begin
    cur_we_s    = we_r;
    cur_uns_s   = uns_r;
    cur_addr_s  = addr_r;
    cur_wdata_s = wdata_r;
    cur_size_s  = size_r;
    if (state_r == S_IDLE) begin
      cur_we_s    = req_we;
      cur_uns_s   = req_unsigned;
      cur_addr_s  = req_addr;
      cur_wdata_s = req_wdata;
      cur_size_s  = req_size;
    end else begin
      cur_we_s    = we_r;
    end
  end

  assign idx_s     = cur_addr_s[AW+2:3];
  assign lane_s    = cur_addr_s[2:0];
  assign fault_s   = align_fault(cur_size_s, lane_s) | (|cur_addr_s[WORDSIZE-1:AW+3]);
  assign rd_word_s = mem_r[idx_s];

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
`ifdef D_MEM_CLEAR_ON_RESET_EN
        if (!clr_done_r) begin
          state_nxt_s = S_CLEAR;
        end else if (req_valid) begin
          state_nxt_s = (LATENCY == 0) ? S_RESP : S_WAIT;
        end else begin
          state_nxt_s = S_IDLE;
        end
`else
        if (req_valid) begin
          state_nxt_s = (LATENCY == 0) ? S_RESP : S_WAIT;
        end else begin
          state_nxt_s = S_IDLE;
        end
`endif
      end
      S_WAIT: begin
        if (cnt_r <= 4'd1) begin
          state_nxt_s = S_RESP;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_RESP: state_nxt_s = S_IDLE;
`ifdef D_MEM_CLEAR_ON_RESET_EN
      S_CLEAR: begin
        if (clr_idx_r == AW'(DEPTH - 1)) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_CLEAR;
        end
      end
`endif
      default: state_nxt_s = S_IDLE;
    endcase
  end

  assign accept_s = (state_r == S_IDLE) && (state_nxt_s == S_WAIT || state_nxt_s == S_RESP);
  assign commit_s = (state_nxt_s == S_RESP);

  // Array write port: zero-fill sweep or committed store.
  always_comb begin
    mem_widx_s  = idx_s;
    mem_wdata_s = store_merge(rd_word_s, cur_wdata_s, cur_size_s, lane_s);
    mem_we_s    = commit_s && cur_we_s && !fault_s;
`ifdef D_MEM_CLEAR_ON_RESET_EN
    if (state_r == S_CLEAR) begin
      mem_we_s    = 1'b1;
      mem_widx_s  = clr_idx_r;
      mem_wdata_s = {WORDSIZE{1'b0}};
    end else begin
      mem_we_s    = commit_s && cur_we_s && !fault_s;
    end
`endif
  end

  // Storage array, intentionally without reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_widx_s] <= mem_wdata_s;
    end
  end

  // State, request capture, wait counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      cnt_r       <= 4'd0;
      we_r        <= 1'b0;
      uns_r       <= 1'b0;
      addr_r      <= {WORDSIZE{1'b0}};
      wdata_r     <= {WORDSIZE{1'b0}};
      size_r      <= 2'd0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {WORDSIZE{1'b0}};
      rsp_fault_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        we_r    <= req_we;
        uns_r   <= req_unsigned;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
        size_r  <= req_size;
        cnt_r   <= 4'(LATENCY);
      end else if (state_r == S_WAIT) begin
        cnt_r <= cnt_r - 4'd1;
      end
      req_ready_r <= (state_nxt_s == S_IDLE);
      busy_r      <= (state_nxt_s != S_IDLE);
      rsp_valid_r <= commit_s;
      rsp_fault_r <= commit_s && fault_s;
      rsp_rdata_r <= (commit_s && !cur_we_s && !fault_s)
                     ? load_extract(rd_word_s, cur_size_s, lane_s, cur_uns_s)
                     : {WORDSIZE{1'b0}};
    end
  end

`ifdef D_MEM_CLEAR_ON_RESET_EN
  // Zero-fill sweep bookkeeping; runs once after each reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_done_r <= 1'b0;
      clr_idx_r  <= {AW{1'b0}};
    end else if (state_r == S_CLEAR) begin
      clr_idx_r <= clr_idx_r + 1'b1;
      if (state_nxt_s == S_IDLE) begin
        clr_done_r <= 1'b1;
      end
    end
  end
`endif

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_fault = rsp_fault_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_d_mem_resp.sv
// Directed self-checking bench for d_mem_resp (DEPTH=256, LATENCY=2).
module tb_d_mem_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_fault;
  logic        busy;

  int errors = 0;
  int checks = 0;

`ifdef D_MEM_CLEAR_ON_RESET_EN
  localparam logic        EXP_READY_AFTER_REL = 1'b0;
  localparam int          EXP_LOW_CYCLES      = 256;
  localparam logic [63:0] EXP_AFTER_RESET     = 64'h0;
`else
  localparam logic        EXP_READY_AFTER_REL = 1'b1;
  localparam int          EXP_LOW_CYCLES      = 0;
  localparam logic [63:0] EXP_AFTER_RESET     = 64'h0123456789ABCDEF;
`endif

  d_mem_resp #(.WORDSIZE(64), .DEPTH(256), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault), .busy(busy)
  );

  always #5 clk = ~clk;

  // Issues one request and returns response latency (cycles after accept) and payload.
  task automatic do_req(input logic we, input logic [63:0] addr, input logic [1:0] size,
                        input logic uns, input logic [63:0] wdata,
                        output int lat, output logic [63:0] rdata, output logic fault);
    int w;
    w = 0;
    while (!req_ready && w < 400) begin
      @(posedge clk); #1; w++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: req_ready=%b required 1", req_ready);
    end
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    rdata = rsp_rdata;
    fault = rsp_fault;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 64'h0;
    req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 64'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 64'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", rsp_rdata); end
    checks++; if (rsp_fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b want 0", rsp_fault); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== EXP_READY_AFTER_REL) begin
      errors++; $display("FAIL rel_ready: got %b want %b", req_ready, EXP_READY_AFTER_REL);
    end
  endtask

  task automatic test_dword();
    int lat; logic [63:0] rd; logic f;
    do_req(1'b1, 64'h10, 2'd3, 1'b0, 64'h1122334455667788, lat, rd, f);
    checks++; if (lat != 3) begin errors++; $display("FAIL st_lat: got %0d want 3", lat); end
    checks++; if (f !== 1'b0 || rd !== 64'h0) begin errors++; $display("FAIL st_rsp: fault=%b rdata=%h want 0/0", f, rd); end
    do_req(1'b0, 64'h10, 2'd3, 1'b0, 64'h0, lat, rd, f);
    checks++; if (lat != 3) begin errors++; $display("FAIL ld_lat: got %0d want 3", lat); end
    checks++; if (rd !== 64'h1122334455667788) begin errors++; $display("FAIL ld_dword: got %h want 1122334455667788", rd); end
    checks++; if (f !== 1'b0) begin errors++; $display("FAIL ld_fault: got %b want 0", f); end
  endtask

  task automatic test_extend();
    int lat; logic [63:0] rd; logic f;
    do_req(1'b1, 64'h11, 2'd0, 1'b0, 64'hAAAAAAAAAAAAAA80, lat, rd, f);
    checks++; if (f !== 1'b0) begin errors++; $display("FAIL sb_fault: got %b want 0", f); end
    do_req(1'b0, 64'h11, 2'd0, 1'b0, 64'h0, lat, rd, f);
    checks++; if (rd !== 64'hFFFFFFFFFFFFFF80) begin errors++; $display("FAIL lb_signed: got %h want ffffffffffffff80", rd); end
    do_req(1'b0, 64'h11, 2'd0, 1'b1, 64'h0, lat, rd, f);
    checks++; if (rd !== 64'h80) begin errors++; $display("FAIL lb_unsigned: got %h want 80", rd); end
    do_req(1'b0, 64'h10, 2'd3, 1'b0, 64'h0, lat, rd, f);
    checks++; if (rd !== 64'h1122334455668088) begin errors++; $display("FAIL ld_merged: got %h want 1122334455668088", rd); end
    do_req(1'b0, 64'h16, 2'd1, 1'b0, 64'h0, lat, rd, f);
    checks++; if (rd !== 64'h1122) begin errors++; $display("FAIL lh_signed: got %h want 1122", rd); end
    do_req(1'b0, 64'h14, 2'd2, 1'b0, 64'h0, lat, rd, f);
    checks++; if (rd !== 64'h11223344) begin errors++; $display("FAIL lw_signed: got %h want 11223344", rd); end
    do_req(1'b0, 64'h10, 2'd1, 1'b0, 64'h0, lat, rd, f);
    checks++; if (rd !== 64'hFFFFFFFFFFFF8088) begin errors++; $display("FAIL lh_neg: got %h want ffffffffffff8088", rd); end
  endtask

  task automatic test_faults();
    int lat; logic [63:0] rd; logic f;
    do_req(1'b0, 64'h13, 2'd1, 1'b0, 64'h0, lat, rd, f);
    checks++; if (f !== 1'b1 || rd !== 64'h0) begin errors++; $display("FAIL misalign_ld: fault=%b rdata=%h want 1/0", f, rd); end
    do_req(1'b1, 64'h16, 2'd2, 1'b0, 64'hDEADBEEFCAFEF00D, lat, rd, f);
    checks++; if (f !== 1'b1) begin errors++; $display("FAIL misalign_st: fault=%b want 1", f); end
    checks++; if (lat != 3) begin errors++; $display("FAIL fault_lat: got %0d want 3", lat); end
    do_req(1'b0, 64'h10, 2'd3, 1'b0, 64'h0, lat, rd, f);
    checks++; if (rd !== 64'h1122334455668088) begin errors++; $display("FAIL unchanged: got %h want 1122334455668088", rd); end
    do_req(1'b0, 64'h800, 2'd3, 1'b0, 64'h0, lat, rd, f);
    checks++; if (f !== 1'b1 || rd !== 64'h0) begin errors++; $display("FAIL range_hi: fault=%b rdata=%h want 1/0", f, rd); end
    do_req(1'b0, 64'h7F8, 2'd3, 1'b0, 64'h0, lat, rd, f);
    checks++; if (f !== 1'b0) begin errors++; $display("FAIL range_top: fault=%b want 0", f); end
  endtask

  task automatic test_back_to_back();
    int acc [3];
    int nacc, pulses, viol, badrd;
    logic drop;
    nacc = 0; pulses = 0; viol = 0; badrd = 0; drop = 1'b0;
    req_we = 1'b0; req_addr = 64'h10; req_size = 2'd3; req_unsigned = 1'b0; req_wdata = 64'h0;
    req_valid = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (req_ready && req_valid && nacc < 3) begin
        acc[nacc] = cyc; nacc++;
        if (nacc == 3) drop = 1'b1;
      end
      if (rsp_valid) begin
        pulses++;
        if (rsp_rdata !== 64'h1122334455668088) badrd++;
      end
      if (busy && req_ready) viol++;
      @(posedge clk); #1;
      if (drop) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    checks++; if (nacc != 3) begin errors++; $display("FAIL b2b_accepts: got %0d want 3", nacc); end
    checks++; if (nacc == 3 && (acc[1] - acc[0] != 4 || acc[2] - acc[1] != 4)) begin
      errors++; $display("FAIL b2b_spacing: got %0d,%0d,%0d want gaps of 4", acc[0], acc[1], acc[2]);
    end
    checks++; if (pulses != 3) begin errors++; $display("FAIL b2b_pulses: got %0d want 3", pulses); end
    checks++; if (viol != 0) begin errors++; $display("FAIL b2b_ready_busy: got %0d overlaps want 0", viol); end
    checks++; if (badrd != 0) begin errors++; $display("FAIL b2b_rdata: got %0d bad want 0", badrd); end
  endtask

  task automatic test_reset_mid();
    int lat, pulses, lowc; logic [63:0] rd; logic f;
    do_req(1'b1, 64'h20, 2'd3, 1'b0, 64'h0123456789ABCDEF, lat, rd, f);
    req_we = 1'b1; req_addr = 64'h20; req_size = 2'd3; req_unsigned = 1'b0;
    req_wdata = 64'hFFFFFFFFFFFFFFFF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin
      errors++; $display("FAIL wait_state: busy=%b ready=%b want 1/0", busy, req_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_fault !== 1'b0 || rsp_rdata !== 64'h0) begin
      errors++; $display("FAIL mid_reset_outs: ready=%b busy=%b valid=%b fault=%b rdata=%h want 1/0/0/0/0",
                         req_ready, busy, rsp_valid, rsp_fault, rsp_rdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pulses = 0; lowc = 0;
    for (int i = 0; i < 300; i++) begin
      if (rsp_valid) pulses++;
      if (!req_ready) lowc++;
      @(posedge clk); #1;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL no_pulse: got %0d want 0", pulses); end
    checks++; if (lowc != EXP_LOW_CYCLES) begin errors++; $display("FAIL clear_cycles: got %0d want %0d", lowc, EXP_LOW_CYCLES); end
    do_req(1'b0, 64'h20, 2'd3, 1'b0, 64'h0, lat, rd, f);
    checks++; if (rd !== EXP_AFTER_RESET || f !== 1'b0) begin
      errors++; $display("FAIL dropped_store: got %h fault=%b want %h/0", rd, f, EXP_AFTER_RESET);
    end
  endtask

  initial begin
    test_reset();
    test_dword();
    test_extend();
    test_faults();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
